// File: rtl/chip8_fetch_unit.sv
// CHIP-8 instruction fetch: owns the PC, reads two big-endian bytes from the
// byte-wide program memory and offers the 16-bit opcode over valid/ready.
module chip8_fetch_unit #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] PC_RESET = 12'h200
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   input  logic              halt,
   output logic [15:0]       opcode,
   output logic [ADDR_W-1:0] opcode_pc,
   output logic              opcode_valid,
   input  logic              opcode_ready,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   input  logic              pc_skip
);

   // state   | meaning
   // S_HI    | present pc to memory (unless halted)
   // S_LO    | capture byte[pc], present pc+1
   // S_WAIT  | capture byte[pc+1], assemble opcode
   // S_VALID | opcode offered; PC update on accept
   typedef enum logic [1:0] {
      S_HI    = 2'd0,
      S_LO    = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        lo_q, lo_d;
   logic [15:0]       opcode_q, opcode_d;
   logic [ADDR_W-1:0] opcode_pc_q, opcode_pc_d;
   logic              valid_q, valid_d;

   logic [ADDR_W-1:0] pc_p1, pc_p2, pc_p4;

   // Address arithmetic wraps at the top of memory.
   assign pc_p1 = pc_q + ADDR_W'(1);
   assign pc_p2 = pc_q + ADDR_W'(2);
   assign pc_p4 = pc_q + ADDR_W'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HI;
         pc_q        <= PC_RESET;
         hi_q        <= '0;
         lo_q        <= '0;
         opcode_q    <= '0;
         opcode_pc_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opcode_q    <= opcode_d;
         opcode_pc_q <= opcode_pc_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opcode_d    = opcode_q;
      opcode_pc_d = opcode_pc_q;
      valid_d     = valid_q;
      mem_addr    = pc_q;
      mem_re      = 1'b0;

      case (state_q)
         S_HI: begin
            mem_addr = pc_q;
            mem_re   = ~halt;
            if (!halt) begin
               state_d = S_LO;
            end
         end
         S_LO: begin
            mem_addr = pc_p1;
            mem_re   = 1'b1;
            hi_d     = mem_rdata;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            mem_addr    = pc_p1;
            lo_d        = mem_rdata;
            opcode_d    = {hi_q, mem_rdata};
            opcode_pc_d = pc_q;
            valid_d     = 1'b1;
            state_d     = S_VALID;
         end
         S_VALID: begin
            mem_addr = pc_q;
            if (valid_q && opcode_ready) begin
               valid_d = 1'b0;
               state_d = S_HI;
               if (pc_load) begin
                  pc_d = pc_target;
               end else if (pc_skip) begin
                  pc_d = pc_p4;
               end else begin
                  pc_d = pc_p2;
               end
            end
         end
         default: begin
            state_d = S_HI;
         end
      endcase
   end

   assign opcode       = opcode_q;
   assign opcode_pc    = opcode_pc_q;
   assign opcode_valid = valid_q;

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// Directed bench for chip8_fetch_unit: byte memory model with one-clock read
// latency, linear stimulus, immediate assertions at each check point.
module tb_chip8_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [11:0] mem_addr;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        halt;
   logic [15:0] opcode;
   logic [11:0] opcode_pc;
   logic        opcode_valid;
   logic        opcode_ready;
   logic        pc_load;
   logic [11:0] pc_target;
   logic        pc_skip;

   logic [7:0]  mem [0:4095];
   int          vectors;
   int          miscompares;

   chip8_fetch_unit #(.ADDR_W(12), .PC_RESET(12'h200)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_addr     (mem_addr),
      .mem_re       (mem_re),
      .mem_rdata    (mem_rdata),
      .halt         (halt),
      .opcode       (opcode),
      .opcode_pc    (opcode_pc),
      .opcode_valid (opcode_valid),
      .opcode_ready (opcode_ready),
      .pc_load      (pc_load),
      .pc_target    (pc_target),
      .pc_skip      (pc_skip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (opcode_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 16'(opcode_valid), 16'h0001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors      = 0;
      miscompares  = 0;
      mem_rdata    = 8'h00;
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
      mem[12'h202] = 8'h6A; mem[12'h203] = 8'h55;
      mem[12'h2A4] = 8'hA1; mem[12'h2A5] = 8'h23;
      mem[12'h2A8] = 8'h3C; mem[12'h2A9] = 8'h07;
      mem[12'hFFF] = 8'h12; mem[12'h000] = 8'h34;
      mem[12'h001] = 8'h56; mem[12'h002] = 8'h78;

      rst_n = 1'b0; halt = 1'b0; opcode_ready = 1'b0;
      pc_load = 1'b0; pc_target = 12'h000; pc_skip = 1'b0;
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_valid",    16'(opcode_valid), 16'h0000);
      chk("rst_opcode",   opcode,            16'h0000);
      chk("rst_opc_pc",   16'(opcode_pc),    16'h0000);
      chk("rst_mem_addr", 16'(mem_addr),     16'h0200);
      chk("rst_mem_re",   16'(mem_re),       16'h0001);

      // T1: first fetch
      rst_n = 1'b1;
      chk("t1_hi_addr", 16'(mem_addr), 16'h0200);
      @(negedge clk);
      chk("t1_lo_addr", 16'(mem_addr), 16'h0201);
      chk("t1_lo_re",   16'(mem_re),   16'h0001);
      @(negedge clk);
      chk("t1_wait_re",    16'(mem_re),       16'h0000);
      chk("t1_wait_valid", 16'(opcode_valid), 16'h0000);
      @(negedge clk);
      chk("t1_valid",  16'(opcode_valid), 16'h0001);
      chk("t1_opcode", opcode,            16'h00E0);
      chk("t1_opc_pc", 16'(opcode_pc),    16'h0200);

      // T2: stall 10 cycles, then accept
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold_opcode", opcode,            16'h00E0);
         chk("t2_hold_opc_pc", 16'(opcode_pc),    16'h0200);
         chk("t2_hold_valid",  16'(opcode_valid), 16'h0001);
         chk("t2_hold_re",     16'(mem_re),       16'h0000);
      end
      opcode_ready = 1'b1;
      @(negedge clk);
      opcode_ready = 1'b0;
      chk("t2_next_addr",  16'(mem_addr),     16'h0202);
      chk("t2_next_re",    16'(mem_re),       16'h0001);
      chk("t2_drop_valid", 16'(opcode_valid), 16'h0000);
      repeat (3) @(negedge clk);
      chk("t2_opcode2", opcode,         16'h6A55);
      chk("t2_opc_pc2", 16'(opcode_pc), 16'h0202);

      // T3: load beats skip; then skip alone
      opcode_ready = 1'b1; pc_load = 1'b1; pc_target = 12'h2A4; pc_skip = 1'b1;
      @(negedge clk);
      opcode_ready = 1'b0; pc_load = 1'b0; pc_target = 12'h000;
      chk("t3_load_addr", 16'(mem_addr), 16'h02A4);
      wait_valid("t3_wait_load");
      chk("t3_opcode", opcode,         16'hA123);
      chk("t3_opc_pc", 16'(opcode_pc), 16'h02A4);
      opcode_ready = 1'b1;
      @(negedge clk);
      opcode_ready = 1'b0; pc_skip = 1'b0;
      chk("t3_skip_addr", 16'(mem_addr), 16'h02A8);
      wait_valid("t3_wait_skip");
      chk("t3_skip_opcode", opcode, 16'h3C07);

      // T4: opcode straddling the top of memory
      opcode_ready = 1'b1; pc_load = 1'b1; pc_target = 12'hFFF;
      @(negedge clk);
      opcode_ready = 1'b0; pc_load = 1'b0;
      chk("t4_hi_addr", 16'(mem_addr), 16'h0FFF);
      @(negedge clk);
      chk("t4_lo_wrap", 16'(mem_addr), 16'h0000);
      repeat (2) @(negedge clk);
      chk("t4_valid",  16'(opcode_valid), 16'h0001);
      chk("t4_opcode", opcode,            16'h1234);
      chk("t4_opc_pc", 16'(opcode_pc),    16'h0FFF);
      opcode_ready = 1'b1;
      @(negedge clk);
      opcode_ready = 1'b0;
      chk("t4_seq_wrap", 16'(mem_addr), 16'h0001);

      // T5: halt raised mid-fetch
      @(negedge clk);
      halt = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_valid",  16'(opcode_valid), 16'h0001);
      chk("t5_opcode", opcode,            16'h5678);
      chk("t5_opc_pc", 16'(opcode_pc),    16'h0001);
      opcode_ready = 1'b1;
      @(negedge clk);
      opcode_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_halt_re",    16'(mem_re),       16'h0000);
         chk("t5_halt_addr",  16'(mem_addr),     16'h0003);
         chk("t5_halt_valid", 16'(opcode_valid), 16'h0000);
         @(negedge clk);
      end
      halt = 1'b0;
      #1;
      chk("t5_resume_re",   16'(mem_re),   16'h0001);
      chk("t5_resume_addr", 16'(mem_addr), 16'h0003);
      @(negedge clk);
      chk("t5_resume_lo", 16'(mem_addr), 16'h0004);
      @(negedge clk);

      // T6: reset during S_WAIT
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid",  16'(opcode_valid), 16'h0000);
      chk("t6_rst_opcode", opcode,            16'h0000);
      chk("t6_rst_addr",   16'(mem_addr),     16'h0200);
      chk("t6_rst_re",     16'(mem_re),       16'h0001);
      @(negedge clk);
      rst_n = 1'b1; pc_load = 1'b1; pc_target = 12'h123;
      wait_valid("t6_wait_restart");
      chk("t6_opcode", opcode,         16'h00E0);
      chk("t6_opc_pc", 16'(opcode_pc), 16'h0200);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_noaccept_addr", 16'(mem_addr), 16'h0200);
      end

      // reset while the opcode is offered drops valid without a clock edge
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 16'(opcode_valid), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1; pc_load = 1'b0; pc_target = 12'h000; opcode_ready = 1'b1;

      // back-to-back throughput: one opcode per 4 clocks
      repeat (3) @(negedge clk);
      chk("tp_valid1",  16'(opcode_valid), 16'h0001);
      chk("tp_opc_pc1", 16'(opcode_pc),    16'h0200);
      @(negedge clk);
      chk("tp_addr2",   16'(mem_addr),     16'h0202);
      chk("tp_gap",     16'(opcode_valid), 16'h0000);
      repeat (3) @(negedge clk);
      chk("tp_valid2",  16'(opcode_valid), 16'h0001);
      chk("tp_opc_pc2", 16'(opcode_pc),    16'h0202);
      chk("tp_opcode2", opcode,            16'h6A55);
      opcode_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
